piezo_arbiter: RTL and testbench

- Shares the single piezo tone generator between three sound requesters: alarm melody, keypad click, and nap-end chime.
- Each requester asks for one tone for a set number of slow ticks. The block grants one requester by fixed priority, drives the piezo's 13-bit `playSound` code for that duration, then inserts a silent gap.
- Sits between the alarm/keypad FSMs and the piezo. It is timed by the enable pulse from the clock divider.

---
 rtl/piezo_pkg.sv | 38 +++
 rtl/piezo_dur_counter.sv | 27 ++
 rtl/piezo_arbiter.sv | 160 ++++++++++++++++
 tb/tb_piezo_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/piezo_pkg.sv
// rtl/piezo_pkg.sv - shared state type, widths and priority helpers for the piezo arbiter
package piezo_pkg;

  localparam int NREQ   = 3;
  localparam int TONE_W = 13;
  localparam int DUR_W  = 8;

  localparam logic [TONE_W-1:0] SILENCE = '0;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  // One-hot of the lowest set bit, which is the highest-priority requester
  function automatic logic [NREQ-1:0] first_set(input logic [NREQ-1:0] r);
    logic [NREQ-1:0] f;
    f = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (r[i]) begin
        f    = '0;
        f[i] = 1'b1;
      end
    end
    return f;
  endfunction

  // All indices strictly below a one-hot owner, i.e. the requesters that outrank it
  function automatic logic [NREQ-1:0] below_mask(input logic [NREQ-1:0] owner);
    logic [NREQ-1:0] m;
    logic            seen;
    m    = '0;
    seen = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      m[i] = seen;
      seen = seen | owner[i];
    end
    return m;
  endfunction

endpackage

// File: rtl/piezo_dur_counter.sv
// rtl/piezo_dur_counter.sv - tick-enabled down counter timing both tones and silent gaps
module piezo_dur_counter
  import piezo_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DUR_W-1:0] load_val,
  input  logic             en,
  output logic             last
);

  logic [DUR_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - DUR_W'(1);
    end
  end

  assign last = en && (cnt == DUR_W'(1));

endmodule

// File: rtl/piezo_arbiter.sv
// rtl/piezo_arbiter.sv - fixed-priority sharing of one piezo tone generator; PIEZO_PREEMPT_EN enables preemption
module piezo_arbiter
  import piezo_pkg::*;
#(
  parameter int GAP_TICKS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [NREQ-1:0]   req,
  input  logic [TONE_W-1:0] tone0,
  input  logic [TONE_W-1:0] tone1,
  input  logic [TONE_W-1:0] tone2,
  input  logic [DUR_W-1:0]  dur0,
  input  logic [DUR_W-1:0]  dur1,
  input  logic [DUR_W-1:0]  dur2,
  output logic [NREQ-1:0]   grant,
  output logic [TONE_W-1:0] play_sound,
  output logic              busy,
  output logic              done
);

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_d, start_vec;
  logic [TONE_W-1:0] play_d, sel_tone;
  logic [DUR_W-1:0]  sel_dur, cnt_val;
  logic              start, preempt, done_d, busy_d, cnt_load, cnt_last, cnt_en;
  logic [TONE_W-1:0] tones [NREQ];
  logic [DUR_W-1:0]  durs  [NREQ];

  assign tones[0] = tone0;
  assign tones[1] = tone1;
  assign tones[2] = tone2;
  assign durs[0]  = dur0;
  assign durs[1]  = dur1;
  assign durs[2]  = dur2;

`ifdef PIEZO_PREEMPT_EN
  logic [NREQ-1:0] owner_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= '0;
    end else if (start) begin
      owner_q <= start_vec;
    end
  end
`endif

  always_comb begin
    start     = 1'b0;
    preempt   = 1'b0;
    start_vec = '0;
    if ((state_q == IDLE) && (|req)) begin
      start     = 1'b1;
      start_vec = first_set(req);
    end
`ifdef PIEZO_PREEMPT_EN
    else if ((state_q == PLAY) && (|(req & below_mask(owner_q)))) begin
      start     = 1'b1;
      preempt   = 1'b1;
      start_vec = first_set(req & below_mask(owner_q));
    end
`endif
  end

  always_comb begin
    sel_tone = SILENCE;
    sel_dur  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (start_vec[i]) begin
        sel_tone = sel_tone | tones[i];
        sel_dur  = sel_dur | durs[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = '0;
    done_d   = 1'b0;
    play_d   = play_sound;
    cnt_load = 1'b0;
    cnt_val  = '0;
    if (start) begin
      grant_d = start_vec;
      done_d  = preempt;
      if (sel_dur == '0) begin
        // Zero-length tone: acknowledge and finish at once, staying silent
        done_d = 1'b1;
        play_d = SILENCE;
        if (GAP_TICKS == 0) begin
          state_d = IDLE;
        end else begin
          state_d  = GAP;
          cnt_load = 1'b1;
          cnt_val  = DUR_W'(GAP_TICKS);
        end
      end else begin
        play_d   = sel_tone;
        state_d  = PLAY;
        cnt_load = 1'b1;
        cnt_val  = sel_dur;
      end
    end else begin
      case (state_q)
        PLAY: begin
          if (cnt_last) begin
            done_d = 1'b1;
            play_d = SILENCE;
            if (GAP_TICKS == 0) begin
              state_d = IDLE;
            end else begin
              state_d  = GAP;
              cnt_load = 1'b1;
              cnt_val  = DUR_W'(GAP_TICKS);
            end
          end
        end
        GAP: begin
          play_d = SILENCE;
          if (cnt_last) begin
            state_d = IDLE;
          end
        end
        default: play_d = SILENCE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // A tick landing in the grant cycle is deliberately not counted
  assign cnt_en = tick && !(|grant);

  piezo_dur_counter u_dur_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .last     (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant      <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      play_sound <= SILENCE;
    end else begin
      state_q    <= state_d;
      grant      <= grant_d;
      done       <= done_d;
      busy       <= busy_d;
      play_sound <= play_d;
    end
  end

endmodule

// File: tb/tb_piezo_arbiter.sv
// tb/tb_piezo_arbiter.sv - randomized bench for piezo_arbiter against a tick-schedule reference model
module tb_piezo_arbiter;

  localparam int GAP  = 2;
  localparam int NCYC = 4000;
  localparam int TMAX = NCYC + 64;
`ifdef PIEZO_PREEMPT_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic [2:0]  req = '0;
  logic [12:0] t_in [3];
  logic [7:0]  d_in [3];
  wire  [12:0] tone0 = t_in[0];
  wire  [12:0] tone1 = t_in[1];
  wire  [12:0] tone2 = t_in[2];
  wire  [7:0]  dur0 = d_in[0];
  wire  [7:0]  dur1 = d_in[1];
  wire  [7:0]  dur2 = d_in[2];
  logic [2:0]  grant;
  logic [12:0] play_sound;
  logic        busy;
  logic        done;

  piezo_arbiter #(.GAP_TICKS(GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .req        (req),
    .tone0      (tone0),
    .tone1      (tone1),
    .tone2      (tone2),
    .dur0       (dur0),
    .dur1       (dur1),
    .dur2       (dur2),
    .grant      (grant),
    .play_sound (play_sound),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int cyc, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  bit tick_at [TMAX];

  // Cycle holding the n-th tick at or after cycle c0
  function automatic int nth(input int c0, input int n);
    int k;
    k = n;
    for (int c = c0; c < TMAX; c++) begin
      if (tick_at[c]) begin
        k--;
        if (k == 0) return c;
      end
    end
    return TMAX + 100;
  endfunction

  // Current transaction: granted at g, done at e, idle again from idl
  bit          v;
  bit          pre;
  int          g, e, idl, d, w;
  logic [12:0] tn;
  logic [2:0]  pending;

  task automatic start_txn(input int gc, input int who, input bit was_pre);
    v   = 1'b1;
    g   = gc;
    w   = who;
    d   = int'(d_in[who]);
    tn  = t_in[who];
    pre = was_pre;
    if (d > 0) begin
      e   = nth(g + 1, d) + 1;
      idl = (GAP > 0) ? nth(e, GAP) + 1 : e;
    end else begin
      e   = g;
      idl = (GAP > 0) ? nth(g + 1, GAP) + 1 : g;
    end
  endtask

  task automatic raise(input int i, input int tone, input int dur);
    if (!pending[i]) begin
      pending[i] = 1'b1;
      t_in[i]    = 13'(tone);
      d_in[i]    = 8'(dur);
    end
  endtask

  function automatic int lowest(input logic [2:0] r);
    for (int i = 0; i < 3; i++) if (r[i]) return i;
    return 0;
  endfunction

  int  eg, ep, ed, eb;
  bit  playing;

  initial begin
    for (int c = 0; c < TMAX; c++) tick_at[c] = ($urandom_range(0, 2) == 0);
    for (int i = 0; i < 3; i++) begin
      t_in[i] = '0;
      d_in[i] = '0;
    end
    pending = '0;
    v = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      if (c >= 1) begin
        eg = (v && c == g) ? (1 << w) : 0;
        ep = (v && d > 0 && c >= g && c < e) ? int'(tn) : 0;
        ed = (v && (c == e || (pre && c == g))) ? 1 : 0;
        eb = (v && c >= g && c < idl) ? 1 : 0;
        check("grant", c, 32'(grant), 32'(eg));
        check("play_sound", c, 32'(play_sound), 32'(ep));
        check("done", c, 32'(done), 32'(ed));
        check("busy", c, 32'(busy), 32'(eb));
      end
      if (v && c == g) begin
        pending[w] = 1'b0;
        t_in[w]    = 13'($urandom_range(0, 8191));
        d_in[w]    = 8'($urandom_range(0, 255));
      end
      rst  = (c < 2) || (c == 240) || (c >= 1500 && c < 1502) || (c == 2700);
      tick = tick_at[c];
      case (c)
        3:   raise(0, 'h0A5, 3);
        60:  begin raise(1, 'h111, 2); raise(2, 'h222, 2); end
        150: raise(2, 'h333, 0);
        180: raise(1, 'h0F0, 1);
        220: raise(1, 'h044, 8);
        300: raise(2, 'h2AA, 10);
        318: raise(0, 'h1FF, 4);
        default: ;
      endcase
      if (c >= 400) begin
        for (int i = 0; i < 3; i++) begin
          if (!pending[i] && $urandom_range(0, 19) == 0)
            raise(i, int'($urandom_range(1, 8191)), int'($urandom_range(0, 5)));
        end
      end
      req = pending;
      if (rst) begin
        v = 1'b0;
      end else begin
        playing = v && d > 0 && c >= g && c < e;
        if ((!v || c >= idl) && pending != 0)
          start_txn(c + 1, lowest(pending), 1'b0);
        else if (PRE && playing && (pending & 3'((1 << w) - 1)) != 0)
          start_txn(c + 1, lowest(pending & 3'((1 << w) - 1)), 1'b1);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
